dispatch_unit: RTL and testbench
================================

# dispatch_unit

Dispatch sits between the instruction queue/decoder and the execution back end. It owns the architectural register file and the register-status (rename) table. Each cycle it takes at most one decoded instruction, allocates a ROB entry, and resolves both source operands to a value or a ROB dependency tag. It then issues the instruction to the reservation station (ALU/branch ops) or the load/store buffer. ROB tag 0 is reserved and means "no dependency" throughout the design.

## Interface
- `REG_NUM`, 32: architectural registers; x0 is hard-wired to 0.
- `ROB_IDX_W`, from `ROB_INDEX_TYPE` in def.v: ROB tag width.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, synchronous and active-low.
- `rdy_in` in 1: global enable; when low, all state holds.
- `clr_in` in 1: mispredict flush.
- `iq_valid`, `iq_op` (OPENUM_TYPE), `iq_rd`/`iq_rs1`/`iq_rs2` (5), `iq_imm` (32), `iq_PC` (32), `iq_is_ls` (1): in; decoded instruction.
- `iq_ready` out 1: instruction accepted this cycle.
- `rob_full` in 1; `rob_next_index` in ROB_IDX_W: the tag the ROB will give the next allocation (never 0).
- `rob_rs1_ready`/`rob_rs2_ready` in 1 and `rob_rs1_val`/`rob_rs2_val` in 32: ROB value-query results.
- `rob_rs1_query`/`rob_rs2_query` out ROB_IDX_W: ROB value-query tags.
- `issue_rob_valid` out 1, `issue_rob_rd` out 5, `issue_rob_op` out OPENUM_TYPE, `issue_rob_PC` out 32: combinational ROB allocation.
- `alu_ready`, `alu_rob_index`, `alu_result` in; `lsb_ready`, `lsb_rob_index`, `lsb_result` in: result broadcasts.
- `commit_valid` in 1, `commit_rd` in 5, `commit_val` in 32, `commit_rob_index` in ROB_IDX_W: ROB commit.
- `rs_full`, `lsb_full` in 1.
- `issue_rs_ready` out 1 plus `issue_rob_index`, `issue_op`, `issue_rs1_val`, `issue_rs1_depend`, `issue_rs2_val`, `issue_rs2_depend`, `issue_imm`, `issue_PC`: registered RS issue bundle.
- `issue_lsb_ready` out 1: registered; the LSB takes the same bundle.

## Operation
- Target selection: the target is the LSB if `iq_is_ls`, else the RS.
  - A target is available iff its full flag is low AND no issue went to it in the previous cycle. This one-bubble rule covers the full-flag lag.
- `iq_ready` = `iq_valid` & !`rob_full` & target available & !`clr_in` & `rdy_in`.
- `issue_rob_valid` = `iq_ready`. `issue_rob_rd`/`op`/`PC` pass straight through from `iq_*`.
- Operand resolution for each of rs1 and rs2. The first matching rule wins:
  1. rs == 0: value 0, dep 0.
  2. tag[rs] == 0: value regfile[rs], dep 0.
  3. `commit_valid` & `commit_rob_index` == tag: value `commit_val`, dep 0.
  4. `alu_ready` & `alu_rob_index` == tag: value `alu_result`, dep 0.
  5. `lsb_ready` & `lsb_rob_index` == tag: value `lsb_result`, dep 0.
  6. ROB query ready: value is the ROB query value, dep 0.
  7. Otherwise: value 0, dep = tag.
- `rob_rsX_query` = tag[rsX] at all times.
- Rename: on accept with rd ≠ 0, tag[rd] <= `rob_next_index`.
- Commit: when `commit_valid` and `commit_rd` ≠ 0:
  - regfile[commit_rd] <= `commit_val`.
  - tag[commit_rd] <= 0 only if tag[commit_rd] == `commit_rob_index` and no same-cycle rename of that rd. A same-cycle rename wins.
- Reads in the cycle of a commit see the pre-write regfile; rule 3 supplies the committed value.

## Timing
- Reset (`rst_in` low at an edge): regfile, tags, `issue_rs_ready`, `issue_lsb_ready`, and every registered bundle field go to 0.
- Latency: an instruction accepted in cycle t is seen at the RS/LSB in cycle t+1. `issue_*_ready` is a one-cycle pulse. The ROB allocates at the edge ending cycle t.
- Back-to-back issue is allowed when the targets alternate. Same-target issue gets one bubble.
- `clr_in`:
  - At the edge: all tags <= 0, `issue_*_ready` <= 0, no accept.
  - A commit presented in the same cycle still writes the regfile.
- `rdy_in` low: no state changes and `iq_ready` = 0. Outputs hold.

## Structure
- def.v holds `OPENUM_TYPE`, `ROB_INDEX_TYPE`, `DATA_TYPE`, `ADDR_TYPE`, `REG_NUM`, and the `TRUE`/`FALSE` constants.
- Sub-module `regfile_tag_table`: the 32×32 value array plus the 32×ROB_IDX_W tag array, with two read ports, one rename write, one commit write, and flush.
- Operand resolution stays in `dispatch_unit` as a shared function instantiated twice.

## Test plan
- Reset, then `add` x3 ← x1, x2 with empty tags. Required: next cycle `issue_rs_ready` = 1, deps 0, vals 0, `issue_rob_index` = `rob_next_index` (e.g. 5); tag[3] = 5.
- Issue `addi` x4 ← x3 while tag[3] = 5 and nothing has broadcast. Required: `issue_rs1_depend` = 5. Repeat with `alu_ready` = 1, index 5, result 0x1234 in the same cycle. Required: dep 0, val 0x1234.
- Commit rd = 3, index 5, val 7 in the same cycle as a new rename of x3 to tag 6. Required: regfile[3] = 7, tag[3] = 6. Then commit index 6, val 9. Required: tag[3] = 0.
- Two consecutive ALU instructions with `rs_full` = 0. Required: the second waits one cycle (`iq_ready` = 0, then 1). A load following an ALU op issues with no bubble.
- Rename x5..x7, then pulse `clr_in` alongside commit rd = 5, val 0xAA. Required: all tags 0, regfile[5] = 0xAA, no issue pulse in the next cycle.
- `rob_full` = 1 or x0 as a destination. Required: no accept while full; x0 is never renamed and always reads 0.

Source files
------------

// File: rtl/dispatch_unit_pkg.sv
// dispatch_unit_pkg: shared widths, types and constants for the dispatch slice.
// Replaces the legacy def.v macro header (OPENUM_TYPE, ROB_INDEX_TYPE,
// DATA_TYPE, ADDR_TYPE, REG_NUM, TRUE/FALSE).
package dispatch_unit_pkg;

   localparam int unsigned REG_NUM_DEF   = 32;
   localparam int unsigned REG_IDX_W     = 5;
   localparam int unsigned ROB_IDX_W_DEF = 4;
   localparam int unsigned OP_W          = 6;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned ADDR_W        = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef logic [OP_W-1:0]      openum_t;
   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // Issue destination of a decoded instruction.
   typedef enum logic {
      TGT_RS  = 1'b0,
      TGT_LSB = 1'b1
   } target_e;

endpackage

// File: rtl/dispatch_unit_regfile.sv
// regfile_tag_table: architectural register values plus the register-status
// (rename) table. A tag of 0 means the register value is architectural.
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   en_i                  : global enable; when low nothing changes
//   flush_i               : clear every tag (commit value write still happens)
//   rs1_i/rs2_i           : read addresses -> *_val_o (value), *_tag_o (tag)
//   ren_we_i/rd/tag       : rename write, tag[rd] <= tag
//   cm_we_i/rd/val/tag    : commit write, value always, tag cleared on match
module regfile_tag_table
   import dispatch_unit_pkg::*;
#(
   parameter int unsigned REG_NUM   = REG_NUM_DEF,
   parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 flush_i,
   input  logic [REG_IDX_W-1:0] rs1_i,
   input  logic [REG_IDX_W-1:0] rs2_i,
   output logic [DATA_W-1:0]    rs1_val_o,
   output logic [DATA_W-1:0]    rs2_val_o,
   output logic [ROB_IDX_W-1:0] rs1_tag_o,
   output logic [ROB_IDX_W-1:0] rs2_tag_o,
   input  logic                 ren_we_i,
   input  logic [REG_IDX_W-1:0] ren_rd_i,
   input  logic [ROB_IDX_W-1:0] ren_tag_i,
   input  logic                 cm_we_i,
   input  logic [REG_IDX_W-1:0] cm_rd_i,
   input  logic [DATA_W-1:0]    cm_val_i,
   input  logic [ROB_IDX_W-1:0] cm_tag_i
);

   data_t                regs_q [REG_NUM];
   logic [ROB_IDX_W-1:0] tags_q [REG_NUM];

   logic cm_write;
   logic ren_write;
   logic cm_clear_tag;

   assign cm_write  = cm_we_i && (cm_rd_i != '0);
   assign ren_write = ren_we_i && (ren_rd_i != '0);

   // Only the producer named by the tag may release it, and a rename of the
   // same register in this cycle takes precedence over the release.
   assign cm_clear_tag = cm_write && (tags_q[cm_rd_i] == cm_tag_i) &&
                         !(ren_write && (ren_rd_i == cm_rd_i));

   assign rs1_val_o = regs_q[rs1_i];
   assign rs2_val_o = regs_q[rs2_i];
   assign rs1_tag_o = tags_q[rs1_i];
   assign rs2_tag_o = tags_q[rs2_i];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
            tags_q[i] <= '0;
         end
      end else if (en_i) begin
         if (cm_write) begin
            regs_q[cm_rd_i] <= cm_val_i;
         end
         if (flush_i) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
               tags_q[i] <= '0;
            end
         end else begin
            if (cm_clear_tag) begin
               tags_q[cm_rd_i] <= '0;
            end
            if (ren_write) begin
               tags_q[ren_rd_i] <= ren_tag_i;
            end
         end
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: accepts one decoded instruction per cycle, allocates a ROB
// entry, resolves both source operands to a value or ROB dependency tag, and
// issues a registered bundle to the reservation station or load/store buffer.
// ROB tag 0 means "no dependency".
//   clk_in, rst_in (sync, active-low), rdy_in (global enable), clr_in (flush)
//   iq_*            : decoded instruction in, iq_ready = accepted this cycle
//   rob_*           : ROB state / value-query port, issue_rob_* allocation
//   alu_*, lsb_*    : result broadcasts; commit_* : ROB commit
//   rs_full/lsb_full: back-end occupancy
//   issue_*         : registered bundle, issue_rs_ready/issue_lsb_ready pulse
module dispatch_unit
   import dispatch_unit_pkg::*;
#(
   parameter int unsigned REG_NUM   = REG_NUM_DEF,
   parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,
   input  logic                 iq_valid,
   input  logic [OP_W-1:0]      iq_op,
   input  logic [4:0]           iq_rd,
   input  logic [4:0]           iq_rs1,
   input  logic [4:0]           iq_rs2,
   input  logic [31:0]          iq_imm,
   input  logic [31:0]          iq_PC,
   input  logic                 iq_is_ls,
   output logic                 iq_ready,
   input  logic                 rob_full,
   input  logic [ROB_IDX_W-1:0] rob_next_index,
   input  logic                 rob_rs1_ready,
   input  logic                 rob_rs2_ready,
   input  logic [31:0]          rob_rs1_val,
   input  logic [31:0]          rob_rs2_val,
   output logic [ROB_IDX_W-1:0] rob_rs1_query,
   output logic [ROB_IDX_W-1:0] rob_rs2_query,
   output logic                 issue_rob_valid,
   output logic [4:0]           issue_rob_rd,
   output logic [OP_W-1:0]      issue_rob_op,
   output logic [31:0]          issue_rob_PC,
   input  logic                 alu_ready,
   input  logic [ROB_IDX_W-1:0] alu_rob_index,
   input  logic [31:0]          alu_result,
   input  logic                 lsb_ready,
   input  logic [ROB_IDX_W-1:0] lsb_rob_index,
   input  logic [31:0]          lsb_result,
   input  logic                 commit_valid,
   input  logic [4:0]           commit_rd,
   input  logic [31:0]          commit_val,
   input  logic [ROB_IDX_W-1:0] commit_rob_index,
   input  logic                 rs_full,
   input  logic                 lsb_full,
   output logic                 issue_rs_ready,
   output logic [ROB_IDX_W-1:0] issue_rob_index,
   output logic [OP_W-1:0]      issue_op,
   output logic [31:0]          issue_rs1_val,
   output logic [ROB_IDX_W-1:0] issue_rs1_depend,
   output logic [31:0]          issue_rs2_val,
   output logic [ROB_IDX_W-1:0] issue_rs2_depend,
   output logic [31:0]          issue_imm,
   output logic [31:0]          issue_PC,
   output logic                 issue_lsb_ready
);

   typedef struct packed {
      data_t                val;
      logic [ROB_IDX_W-1:0] dep;
   } operand_t;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      openum_t              op;
      operand_t             src1;
      operand_t             src2;
      data_t                imm;
      addr_t                pc;
   } bundle_t;

   // First matching source wins: x0, architectural value, then the newest
   // forwarding paths (commit, ALU, LSB), then the ROB's stored result.
   function automatic operand_t resolve_operand(
      input reg_idx_t             rs,
      input data_t                rf_val,
      input logic [ROB_IDX_W-1:0] tag,
      input logic                 cm_vld,
      input logic [ROB_IDX_W-1:0] cm_idx,
      input data_t                cm_val,
      input logic                 alu_vld,
      input logic [ROB_IDX_W-1:0] alu_idx,
      input data_t                alu_val,
      input logic                 lsb_vld,
      input logic [ROB_IDX_W-1:0] lsb_idx,
      input data_t                lsb_val,
      input logic                 rob_vld,
      input data_t                rob_val
   );
      operand_t res;
      res = '0;
      if (rs == '0) begin
         res = '0;
      end else if (tag == '0) begin
         res.val = rf_val;
      end else if (cm_vld && (cm_idx == tag)) begin
         res.val = cm_val;
      end else if (alu_vld && (alu_idx == tag)) begin
         res.val = alu_val;
      end else if (lsb_vld && (lsb_idx == tag)) begin
         res.val = lsb_val;
      end else if (rob_vld) begin
         res.val = rob_val;
      end else begin
         res.dep = tag;
      end
      return res;
   endfunction

   data_t                rf_rs1_val;
   data_t                rf_rs2_val;
   logic [ROB_IDX_W-1:0] rf_rs1_tag;
   logic [ROB_IDX_W-1:0] rf_rs2_tag;

   operand_t src1;
   operand_t src2;

   target_e tgt;
   logic    tgt_avail;
   logic    accept;

   logic    rs_rdy_q,  rs_rdy_d;
   logic    lsb_rdy_q, lsb_rdy_d;
   bundle_t bundle_q,  bundle_d;

   regfile_tag_table #(
      .REG_NUM   (REG_NUM),
      .ROB_IDX_W (ROB_IDX_W)
   ) u_regfile (
      .clk_i     (clk_in),
      .rst_ni    (rst_in),
      .en_i      (rdy_in),
      .flush_i   (clr_in),
      .rs1_i     (iq_rs1),
      .rs2_i     (iq_rs2),
      .rs1_val_o (rf_rs1_val),
      .rs2_val_o (rf_rs2_val),
      .rs1_tag_o (rf_rs1_tag),
      .rs2_tag_o (rf_rs2_tag),
      .ren_we_i  (accept),
      .ren_rd_i  (iq_rd),
      .ren_tag_i (rob_next_index),
      .cm_we_i   (commit_valid),
      .cm_rd_i   (commit_rd),
      .cm_val_i  (commit_val),
      .cm_tag_i  (commit_rob_index)
   );

   assign tgt = iq_is_ls ? TGT_LSB : TGT_RS;

   // A target that received an issue last cycle is treated as busy: its full
   // flag does not yet reflect that entry.
   always_comb begin
      tgt_avail = 1'b0;
      unique case (tgt)
         TGT_RS:  tgt_avail = !rs_full  && !rs_rdy_q;
         TGT_LSB: tgt_avail = !lsb_full && !lsb_rdy_q;
         default: tgt_avail = 1'b0;
      endcase
   end

   assign accept   = iq_valid && !rob_full && tgt_avail && !clr_in && rdy_in;
   assign iq_ready = accept;

   assign issue_rob_valid = accept;
   assign issue_rob_rd    = iq_rd;
   assign issue_rob_op    = iq_op;
   assign issue_rob_PC    = iq_PC;

   assign rob_rs1_query = rf_rs1_tag;
   assign rob_rs2_query = rf_rs2_tag;

   assign src1 = resolve_operand(iq_rs1, rf_rs1_val, rf_rs1_tag,
                                 commit_valid, commit_rob_index, commit_val,
                                 alu_ready, alu_rob_index, alu_result,
                                 lsb_ready, lsb_rob_index, lsb_result,
                                 rob_rs1_ready, rob_rs1_val);
   assign src2 = resolve_operand(iq_rs2, rf_rs2_val, rf_rs2_tag,
                                 commit_valid, commit_rob_index, commit_val,
                                 alu_ready, alu_rob_index, alu_result,
                                 lsb_ready, lsb_rob_index, lsb_result,
                                 rob_rs2_ready, rob_rs2_val);

   always_comb begin
      rs_rdy_d  = rs_rdy_q;
      lsb_rdy_d = lsb_rdy_q;
      bundle_d  = bundle_q;
      if (rdy_in) begin
         if (clr_in) begin
            rs_rdy_d  = 1'b0;
            lsb_rdy_d = 1'b0;
         end else begin
            rs_rdy_d  = accept && (tgt == TGT_RS);
            lsb_rdy_d = accept && (tgt == TGT_LSB);
            if (accept) begin
               bundle_d.rob_idx = rob_next_index;
               bundle_d.op      = iq_op;
               bundle_d.src1    = src1;
               bundle_d.src2    = src2;
               bundle_d.imm     = iq_imm;
               bundle_d.pc      = iq_PC;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rs_rdy_q  <= 1'b0;
         lsb_rdy_q <= 1'b0;
         bundle_q  <= '0;
      end else begin
         rs_rdy_q  <= rs_rdy_d;
         lsb_rdy_q <= lsb_rdy_d;
         bundle_q  <= bundle_d;
      end
   end

   assign issue_rs_ready   = rs_rdy_q;
   assign issue_lsb_ready  = lsb_rdy_q;
   assign issue_rob_index  = bundle_q.rob_idx;
   assign issue_op         = bundle_q.op;
   assign issue_rs1_val    = bundle_q.src1.val;
   assign issue_rs1_depend = bundle_q.src1.dep;
   assign issue_rs2_val    = bundle_q.src2.val;
   assign issue_rs2_depend = bundle_q.src2.dep;
   assign issue_imm        = bundle_q.imm;
   assign issue_PC         = bundle_q.pc;

endmodule

// File: tb/tb_dispatch_unit.sv
module tb_dispatch_unit;
   import dispatch_unit_pkg::*;

   localparam int unsigned RW = ROB_IDX_W_DEF;

   typedef struct packed {
      logic          rs;
      logic          lsb;
      logic [RW-1:0] idx;
      logic [5:0]    op;
      logic [31:0]   v1;
      logic [RW-1:0] d1;
      logic [31:0]   v2;
      logic [RW-1:0] d2;
      logic [31:0]   imm;
      logic [31:0]   pc;
   } bundle_t;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, clr_in;
   logic          iq_valid, iq_is_ls, iq_ready;
   logic [5:0]    iq_op;
   logic [4:0]    iq_rd, iq_rs1, iq_rs2;
   logic [31:0]   iq_imm, iq_PC;
   logic          rob_full, rob_rs1_ready, rob_rs2_ready;
   logic [RW-1:0] rob_next_index, rob_rs1_query, rob_rs2_query;
   logic [31:0]   rob_rs1_val, rob_rs2_val;
   logic          issue_rob_valid;
   logic [4:0]    issue_rob_rd;
   logic [5:0]    issue_rob_op;
   logic [31:0]   issue_rob_PC;
   logic          alu_ready, lsb_ready, commit_valid;
   logic [RW-1:0] alu_rob_index, lsb_rob_index, commit_rob_index;
   logic [31:0]   alu_result, lsb_result, commit_val;
   logic [4:0]    commit_rd;
   logic          rs_full, lsb_full;
   logic          issue_rs_ready, issue_lsb_ready;
   logic [RW-1:0] issue_rob_index, issue_rs1_depend, issue_rs2_depend;
   logic [5:0]    issue_op;
   logic [31:0]   issue_rs1_val, issue_rs2_val, issue_imm, issue_PC;

   int      n_checks = 0;
   int      n_errors = 0;
   bundle_t sb[$];
   bundle_t exp_b, obs_b;

   always #5 clk_in = ~clk_in;

   dispatch_unit #(.REG_NUM(32), .ROB_IDX_W(RW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .iq_valid(iq_valid), .iq_op(iq_op), .iq_rd(iq_rd), .iq_rs1(iq_rs1),
      .iq_rs2(iq_rs2), .iq_imm(iq_imm), .iq_PC(iq_PC), .iq_is_ls(iq_is_ls),
      .iq_ready(iq_ready), .rob_full(rob_full), .rob_next_index(rob_next_index),
      .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
      .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
      .rob_rs1_query(rob_rs1_query), .rob_rs2_query(rob_rs2_query),
      .issue_rob_valid(issue_rob_valid), .issue_rob_rd(issue_rob_rd),
      .issue_rob_op(issue_rob_op), .issue_rob_PC(issue_rob_PC),
      .alu_ready(alu_ready), .alu_rob_index(alu_rob_index), .alu_result(alu_result),
      .lsb_ready(lsb_ready), .lsb_rob_index(lsb_rob_index), .lsb_result(lsb_result),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_rob_index(commit_rob_index), .rs_full(rs_full), .lsb_full(lsb_full),
      .issue_rs_ready(issue_rs_ready), .issue_rob_index(issue_rob_index),
      .issue_op(issue_op), .issue_rs1_val(issue_rs1_val),
      .issue_rs1_depend(issue_rs1_depend), .issue_rs2_val(issue_rs2_val),
      .issue_rs2_depend(issue_rs2_depend), .issue_imm(issue_imm),
      .issue_PC(issue_PC), .issue_lsb_ready(issue_lsb_ready)
   );

   function automatic bundle_t mk(input logic rs, input logic lsb, input logic [RW-1:0] idx,
                                  input logic [5:0] op, input logic [31:0] v1,
                                  input logic [RW-1:0] d1, input logic [31:0] v2,
                                  input logic [RW-1:0] d2, input logic [31:0] imm,
                                  input logic [31:0] pc);
      bundle_t b;
      b = '{rs: rs, lsb: lsb, idx: idx, op: op, v1: v1, d1: d1, v2: v2, d2: d2,
            imm: imm, pc: pc};
      return b;
   endfunction

   function automatic bundle_t observe();
      bundle_t b;
      b = '{rs: issue_rs_ready, lsb: issue_lsb_ready, idx: issue_rob_index, op: issue_op,
            v1: issue_rs1_val, d1: issue_rs1_depend, v2: issue_rs2_val,
            d2: issue_rs2_depend, imm: issue_imm, pc: issue_PC};
      return b;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send(input logic ls, input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [RW-1:0] nidx);
      iq_valid = 1'b1; iq_is_ls = ls; iq_op = op; iq_rd = rd;
      iq_rs1 = rs1; iq_rs2 = rs2; iq_imm = imm; iq_PC = pc;
      rob_next_index = nidx;
   endtask

   task automatic test_reset();
      rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
      iq_valid = 0; iq_is_ls = 0; iq_op = '0; iq_rd = '0; iq_rs1 = '0; iq_rs2 = '0;
      iq_imm = '0; iq_PC = '0; rob_full = 0; rob_next_index = '0;
      rob_rs1_ready = 0; rob_rs2_ready = 0; rob_rs1_val = '0; rob_rs2_val = '0;
      alu_ready = 0; alu_rob_index = '0; alu_result = '0;
      lsb_ready = 0; lsb_rob_index = '0; lsb_result = '0;
      commit_valid = 0; commit_rd = '0; commit_val = '0; commit_rob_index = '0;
      rs_full = 0; lsb_full = 0;
      tick(); tick();
      obs_b = observe(); n_checks++;
      if (obs_b !== '0) begin
         n_errors++; $display("FAIL reset_bundle: got %h expected 0", obs_b);
      end
      iq_rs1 = 5'd3; iq_rs2 = 5'd31; #1;
      n_checks++;
      if ({rob_rs1_query, rob_rs2_query} !== '0) begin
         n_errors++; $display("FAIL reset_tags: got %h/%h expected 0/0", rob_rs1_query, rob_rs2_query);
      end
      rst_in = 1'b1;
      tick();
   endtask

   task automatic test_basic_add();
      send(1'b0, 6'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h100, 4'd5);
      #1;
      n_checks++;
      if ({iq_ready, issue_rob_valid, issue_rob_rd, issue_rob_PC} !== {1'b1, 1'b1, 5'd3, 32'h100}) begin
         n_errors++;
         $display("FAIL add_accept: got rdy=%b rv=%b rd=%0d pc=%h expected 1 1 3 100",
                  iq_ready, issue_rob_valid, issue_rob_rd, issue_rob_PC);
      end
      sb.push_back(mk(1, 0, 4'd5, 6'd1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 32'h100));
      tick();
      iq_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL add_issue: got %h expected %h", obs_b, exp_b);
      end
      iq_rs1 = 5'd3; #1;
      n_checks++;
      if (rob_rs1_query !== 4'd5) begin
         n_errors++; $display("FAIL add_rename: got %0d expected 5", rob_rs1_query);
      end
   endtask

   task automatic test_dependency();
      tick();
      n_checks++;
      if (issue_rs_ready !== 1'b0) begin
         n_errors++; $display("FAIL rs_pulse_width: got %b expected 0", issue_rs_ready);
      end
      send(1'b0, 6'd2, 5'd4, 5'd3, 5'd0, 32'h10, 32'h104, 4'd6);
      sb.push_back(mk(1, 0, 4'd6, 6'd2, 32'h0, 4'd5, 32'h0, 4'd0, 32'h10, 32'h104));
      tick(); iq_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL dep_wait: got %h expected %h", obs_b, exp_b);
      end
      tick();
      send(1'b0, 6'd2, 5'd4, 5'd3, 5'd0, 32'h10, 32'h108, 4'd7);
      alu_ready = 1'b1; alu_rob_index = 4'd5; alu_result = 32'h1234;
      sb.push_back(mk(1, 0, 4'd7, 6'd2, 32'h1234, 4'd0, 32'h0, 4'd0, 32'h10, 32'h108));
      tick(); iq_valid = 1'b0; alu_ready = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL dep_alu_fwd: got %h expected %h", obs_b, exp_b);
      end
      tick();
      // rs1 = x3 (tag 5) answered by the ROB, rs2 = x4 (tag 7) by the LSB broadcast
      send(1'b0, 6'd2, 5'd4, 5'd3, 5'd4, 32'h0, 32'h10c, 4'd8);
      rob_rs1_ready = 1'b1; rob_rs1_val = 32'h55;
      lsb_ready = 1'b1; lsb_rob_index = 4'd7; lsb_result = 32'h77;
      sb.push_back(mk(1, 0, 4'd8, 6'd2, 32'h55, 4'd0, 32'h77, 4'd0, 32'h0, 32'h10c));
      tick(); iq_valid = 1'b0; rob_rs1_ready = 1'b0; lsb_ready = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL dep_rob_lsb_fwd: got %h expected %h", obs_b, exp_b);
      end
   endtask

   task automatic test_commit_rename();
      tick();
      commit_valid = 1'b1; commit_rd = 5'd3; commit_rob_index = 4'd5; commit_val = 32'd7;
      send(1'b0, 6'd1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h200, 4'd6);
      sb.push_back(mk(1, 0, 4'd6, 6'd1, 32'd7, 4'd0, 32'h0, 4'd0, 32'h0, 32'h200));
      tick(); iq_valid = 1'b0; commit_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL commit_fwd: got %h expected %h", obs_b, exp_b);
      end
      n_checks++;
      if (rob_rs1_query !== 4'd6) begin
         n_errors++; $display("FAIL rename_wins: got tag %0d expected 6", rob_rs1_query);
      end
      commit_valid = 1'b1; commit_rd = 5'd3; commit_rob_index = 4'd5; commit_val = 32'h77;
      tick(); commit_valid = 1'b0;
      n_checks++;
      if (rob_rs1_query !== 4'd6) begin
         n_errors++; $display("FAIL stale_commit: got tag %0d expected 6", rob_rs1_query);
      end
      commit_valid = 1'b1; commit_rd = 5'd3; commit_rob_index = 4'd6; commit_val = 32'd9;
      tick(); commit_valid = 1'b0;
      n_checks++;
      if (rob_rs1_query !== 4'd0) begin
         n_errors++; $display("FAIL commit_clear: got tag %0d expected 0", rob_rs1_query);
      end
      send(1'b0, 6'd1, 5'd10, 5'd3, 5'd3, 32'h0, 32'h204, 4'd7);
      sb.push_back(mk(1, 0, 4'd7, 6'd1, 32'd9, 4'd0, 32'd9, 4'd0, 32'h0, 32'h204));
      tick(); iq_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL regfile_read: got %h expected %h", obs_b, exp_b);
      end
   endtask

   task automatic test_back_to_back();
      tick();
      send(1'b0, 6'd1, 5'd8, 5'd0, 5'd0, 32'h0, 32'h300, 4'd9);
      #1;
      n_checks++;
      if (iq_ready !== 1'b1) begin
         n_errors++; $display("FAIL b2b_first: got iq_ready=%b expected 1", iq_ready);
      end
      sb.push_back(mk(1, 0, 4'd9, 6'd1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 32'h300));
      tick();
      send(1'b0, 6'd1, 5'd11, 5'd0, 5'd0, 32'h0, 32'h304, 4'd10);
      #1;
      n_checks++;
      if (iq_ready !== 1'b0) begin
         n_errors++; $display("FAIL b2b_bubble: got iq_ready=%b expected 0", iq_ready);
      end
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL b2b_issue1: got %h expected %h", obs_b, exp_b);
      end
      tick();
      n_checks++;
      if ({iq_ready, issue_rs_ready} !== 2'b10) begin
         n_errors++; $display("FAIL b2b_retry: got iq_ready=%b rs_ready=%b expected 1 0", iq_ready, issue_rs_ready);
      end
      sb.push_back(mk(1, 0, 4'd10, 6'd1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 32'h304));
      tick();
      send(1'b1, 6'd3, 5'd12, 5'd0, 5'd0, 32'h4, 32'h308, 4'd11);
      #1;
      n_checks++;
      if (iq_ready !== 1'b1) begin
         n_errors++; $display("FAIL b2b_load_nobubble: got iq_ready=%b expected 1", iq_ready);
      end
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL b2b_issue2: got %h expected %h", obs_b, exp_b);
      end
      sb.push_back(mk(0, 1, 4'd11, 6'd3, 32'h0, 4'd0, 32'h0, 4'd0, 32'h4, 32'h308));
      tick(); iq_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL b2b_load: got %h expected %h", obs_b, exp_b);
      end
   endtask

   task automatic test_flush();
      tick();
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 6'd1, 5'(5 + i), 5'd0, 5'd0, 32'h0, 32'h400 + 32'(4 * i), 4'(12 + i));
         sb.push_back(mk(1, 0, 4'(12 + i), 6'd1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 32'h400 + 32'(4 * i)));
         tick(); iq_valid = 1'b0;
         exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
         if (obs_b !== exp_b) begin
            n_errors++; $display("FAIL flush_rename%0d: got %h expected %h", i, obs_b, exp_b);
         end
         tick();
      end
      iq_rs1 = 5'd5; iq_rs2 = 5'd7; #1;
      n_checks++;
      if ({rob_rs1_query, rob_rs2_query} !== {4'd12, 4'd14}) begin
         n_errors++; $display("FAIL flush_pre_tags: got %0d/%0d expected 12/14", rob_rs1_query, rob_rs2_query);
      end
      clr_in = 1'b1;
      commit_valid = 1'b1; commit_rd = 5'd5; commit_rob_index = 4'd3; commit_val = 32'hAA;
      send(1'b0, 6'd1, 5'd13, 5'd0, 5'd0, 32'h0, 32'h500, 4'd15);
      #1;
      n_checks++;
      if ({iq_ready, issue_rob_valid} !== 2'b00) begin
         n_errors++; $display("FAIL flush_no_accept: got %b%b expected 00", iq_ready, issue_rob_valid);
      end
      tick();
      clr_in = 1'b0; commit_valid = 1'b0; iq_valid = 1'b0;
      n_checks++;
      if ({issue_rs_ready, issue_lsb_ready} !== 2'b00) begin
         n_errors++; $display("FAIL flush_no_issue: got %b%b expected 00", issue_rs_ready, issue_lsb_ready);
      end
      for (int r = 4; r <= 7; r++) begin
         iq_rs1 = 5'(r); #1;
         n_checks++;
         if (rob_rs1_query !== 4'd0) begin
            n_errors++; $display("FAIL flush_tag_x%0d: got %0d expected 0", r, rob_rs1_query);
         end
      end
      send(1'b0, 6'd1, 5'd13, 5'd5, 5'd0, 32'h0, 32'h504, 4'd1);
      sb.push_back(mk(1, 0, 4'd1, 6'd1, 32'hAA, 4'd0, 32'h0, 4'd0, 32'h0, 32'h504));
      tick(); iq_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL flush_commit_kept: got %h expected %h", obs_b, exp_b);
      end
   endtask

   task automatic test_rob_full_x0();
      tick();
      rob_full = 1'b1;
      send(1'b0, 6'd1, 5'd14, 5'd0, 5'd0, 32'h0, 32'h600, 4'd2);
      #1;
      n_checks++;
      if ({iq_ready, issue_rob_valid} !== 2'b00) begin
         n_errors++; $display("FAIL rob_full: got %b%b expected 00", iq_ready, issue_rob_valid);
      end
      tick();
      n_checks++;
      if (issue_rs_ready !== 1'b0) begin
         n_errors++; $display("FAIL rob_full_issue: got %b expected 0", issue_rs_ready);
      end
      rob_full = 1'b0; rs_full = 1'b1; #1;
      n_checks++;
      if (iq_ready !== 1'b0) begin
         n_errors++; $display("FAIL rs_full: got %b expected 0", iq_ready);
      end
      rs_full = 1'b0; rdy_in = 1'b0; #1;
      n_checks++;
      if (iq_ready !== 1'b0) begin
         n_errors++; $display("FAIL rdy_low: got %b expected 0", iq_ready);
      end
      rdy_in = 1'b1;
      commit_valid = 1'b1; commit_rd = 5'd0; commit_rob_index = 4'd2; commit_val = 32'hFF;
      send(1'b0, 6'd1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h604, 4'd2);
      #1;
      n_checks++;
      if (iq_ready !== 1'b1) begin
         n_errors++; $display("FAIL x0_accept: got %b expected 1", iq_ready);
      end
      sb.push_back(mk(1, 0, 4'd2, 6'd1, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 32'h604));
      tick(); iq_valid = 1'b0; commit_valid = 1'b0;
      exp_b = sb.pop_front(); obs_b = observe(); n_checks++;
      if (obs_b !== exp_b) begin
         n_errors++; $display("FAIL x0_issue: got %h expected %h", obs_b, exp_b);
      end
      iq_rs1 = 5'd0; #1;
      n_checks++;
      if (rob_rs1_query !== 4'd0) begin
         n_errors++; $display("FAIL x0_not_renamed: got %0d expected 0", rob_rs1_query);
      end
   endtask

   initial begin
      fork
         begin
            test_reset();
            test_basic_add();
            test_dependency();
            test_commit_rename();
            test_back_to_back();
            test_flush();
            test_rob_full_x0();
         end
         begin
            #100000;
            $display("FAIL timeout: simulation did not complete");
            $fatal(1, "timeout");
         end
      join_any
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
